instr_stream_encoder: RTL
=========================

# instr_stream_encoder

Sequential loader that encodes RV32I instruction fields into 32-bit machine words and writes them into instruction memory for the single-cycle core. It produces the same six opcode classes the core's main decoder consumes: R-type, I-type ALU, LW, SW, BEQ and JAL. It holds the core in reset while loading and releases it once the program is complete.

## Interface
- DEPTH, 64: instruction memory capacity in words.
- BASE_ADDR, 32'h0: byte address of the first written word.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  field set on `in_*` is valid.
- in_ready  out  1  block accepts a field set this cycle.
- in_class  in  3  0=R, 1=I-ALU, 2=LW, 3=SW, 4=BEQ, 5=JAL; 6 and 7 are illegal.
- in_funct3  in  3  funct3 for R and I-ALU; ignored for the other classes.
- in_funct7b5  in  1  funct7 bit 5 for R; ignored for the other classes.
- in_rd, in_rs1, in_rs2  in  5 each  register indices.
- in_imm  in  32  signed immediate, byte offset for BEQ/JAL.
- in_last  in  1  this field set is the final instruction.
- imem_we  out  1  instruction memory write strobe.
- imem_addr  out  32  byte address, word aligned.
- imem_wdata  out  32  encoded instruction.
- cpu_reset  out  1  holds the core in reset while high.
- done  out  1  program loaded; sticky until reset.
- err  out  1  sticky error flag.
- count  out  $clog2(DEPTH+1)  number of words written.

## Operation
- States: LOAD, WRITE, DONE.
- Reset values: state=LOAD, count=0, in_ready=1, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, cpu_reset=1, done=0, err=0.
- LOAD state:
  - in_ready=1.
  - On handshake (in_valid & in_ready), range-check and encode the fields into a word register, then go to WRITE.
  - An illegal handshake sets err and writes nothing. It stays in LOAD, or goes to DONE if in_last=1.
- Encoding rules (funct3 is fixed to 010 for LW/SW and 000 for BEQ):
  - R: {1'b0, funct7b5, 5'b0, rs2, rs1, funct3, rd, 7'b0110011}.
  - I-ALU: {imm[11:0], rs1, funct3, rd, 7'b0010011}.
  - LW: {imm[11:0], rs1, 3'b010, rd, 7'b0000011}.
  - SW: {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011}.
  - BEQ: {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011}.
  - JAL: {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111}.
- Illegal conditions:
  - class 6 or 7.
  - I-ALU/LW/SW imm outside [-2048, 2047].
  - BEQ imm outside [-4096, 4094], or imm[0]=1.
  - JAL imm outside [-2^20, 2^20-2], or imm[0]=1.
- WRITE state:
  - imem_we=1 for exactly one cycle, with imem_addr=BASE_ADDR+4*count and imem_wdata=the encoded word.
  - count increments at the end of the cycle.
  - Next state is DONE if the latched in_last=1 or the new count equals DEPTH; otherwise LOAD.
- DONE state:
  - in_ready=0, cpu_reset=0, done=1.
  - Remains in DONE until reset; in_valid is ignored.
- Overflow: if count reaches DEPTH without in_last, go to DONE and set err.
- Reset mid-operation: the next cycle returns to reset values. Words already written stay in memory; they are not cleared.

## Timing
- Handshake at edge T: imem_we=1 during cycle T+1; count is updated at edge T+2.
- in_ready is 0 during WRITE. Maximum throughput is one word per 2 cycles.
- done and cpu_reset=0 take effect at the edge that ends the final WRITE cycle.
- An illegal word with in_last: done at edge T+1, with no write.
- err rises at the edge after the offending handshake or the overflow write.
- Outputs are registered; no combinational path from `in_*` to `imem_*`.

## Test plan
- Reset, then add x3,x1,x2 (class 0, funct3 0, funct7b5 0) -> imem_we one cycle, addr 0x0, wdata 0x002081B3, count=1, in_ready high again 2 cycles after handshake.
- lw x5,-4(x2), then sw x5,8(x2) -> writes 0xFFC12283 at 0x0 and 0x00512423 at 0x4.
- beq x1,x2,-8, then jal x1,16 with in_last=1 -> writes 0xFE208CE3 and 0x010000EF; done=1, cpu_reset=0, in_ready=0 afterwards; further in_valid is ignored.
- Illegal inputs: BEQ imm=5, I-ALU imm=2048, class 7 -> err=1 each time, no imem_we, count unchanged; a following legal word is written at the unchanged address.
- DEPTH=4, five words without in_last -> exactly 4 writes at 0x0–0xC, done=1, err=1, fifth word not accepted.
- Assert reset during a WRITE cycle -> next cycle: count=0, cpu_reset=1, in_ready=1, imem_we=0, err=0, done=0.

Source files
------------

// File: rtl/instr_stream_encoder.sv
// Loads encoded RV32I instructions into instruction memory one field set at a time,
// holding the core in reset until the program is complete.
module instr_stream_encoder #(
    parameter int          DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    localparam int         CW        = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_class,
    input  logic [2:0]    in_funct3,
    input  logic          in_funct7b5,
    input  logic [4:0]    in_rd,
    input  logic [4:0]    in_rs1,
    input  logic [4:0]    in_rs2,
    input  logic [31:0]   in_imm,
    input  logic          in_last,
    output logic          imem_we,
    output logic [31:0]   imem_addr,
    output logic [31:0]   imem_wdata,
    output logic          cpu_reset,
    output logic          done,
    output logic          err,
    output logic [CW-1:0] count
);

    typedef enum logic [1:0] {LOAD, WRITE, DONE} state_t;

    state_t             state;
    logic               last_q;
    logic               illegal;
    logic [31:0]        enc;
    logic signed [31:0] simm;
    logic               imm12_bad;
    logic               imm13_bad;
    logic               imm21_bad;

    assign simm      = in_imm;
    assign imm12_bad = (simm < -2048) || (simm > 2047);
    assign imm13_bad = (simm < -4096) || (simm > 4094) || in_imm[0];
    assign imm21_bad = (simm < -1048576) || (simm > 1048574) || in_imm[0];

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        enc     = '0;
        illegal = 1'b0;
        case (in_class)
            3'd0: enc = {1'b0, in_funct7b5, 5'b0, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
            3'd1: begin
                illegal = imm12_bad;
                enc     = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
            end
            3'd2: begin
                illegal = imm12_bad;
                enc     = {in_imm[11:0], in_rs1, 3'b010, in_rd, 7'b0000011};
            end
            3'd3: begin
                illegal = imm12_bad;
                enc     = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'b0100011};
            end
            3'd4: begin
                illegal = imm13_bad;
                enc     = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000,
                           in_imm[4:1], in_imm[11], 7'b1100011};
            end
            3'd5: begin
                illegal = imm21_bad;
                enc     = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'b1101111};
            end
            default: illegal = 1'b1;
        endcase
    end

    // NOTE: state and outputs use non-blocking assignments so every register samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= LOAD;
            last_q     <= 1'b0;
            count      <= '0;
            in_ready   <= 1'b1;
            imem_we    <= 1'b0;
            imem_addr  <= BASE_ADDR;
            imem_wdata <= '0;
            cpu_reset  <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (in_valid && in_ready) begin
                        if (illegal) begin
                            err <= 1'b1;
                            if (in_last) begin
                                state     <= DONE;
                                in_ready  <= 1'b0;
                                cpu_reset <= 1'b0;
                                done      <= 1'b1;
                            end
                        end else begin
                            state      <= WRITE;
                            last_q     <= in_last;
                            in_ready   <= 1'b0;
                            imem_we    <= 1'b1;
                            imem_addr  <= BASE_ADDR + (32'(count) << 2);
                            imem_wdata <= enc;
                        end
                    end
                end
                WRITE: begin
                    imem_we <= 1'b0;
                    count   <= count + CW'(1);
                    if (last_q || count == CW'(DEPTH - 1)) begin
                        state     <= DONE;
                        cpu_reset <= 1'b0;
                        done      <= 1'b1;
                        // Memory filled before the program said it was finished.
                        if (!last_q) err <= 1'b1;
                    end else begin
                        state    <= LOAD;
                        in_ready <= 1'b1;
                    end
                end
                DONE:    ;
                default: state <= LOAD;
            endcase
        end
    end

endmodule
